serial_deser_arbiter: RTL and testbench
=======================================

# serial_deser_arbiter

Shares one LSB-first serial-to-parallel deserializer between `n_lanes` serial requesters. A round-robin arbiter grants one lane at a time. It collects exactly `width` valid bits from the granted lane and presents the assembled word on a valid/ready output port, tagged with the source lane. The block sits between the per-lane serial front-ends and the downstream word consumer, and replaces per-lane deserializers where lane traffic is sparse.

## Interface
- `n_lanes`, 4: number of serial requesters; must be ≥ 2.
- `width`, 8: bits per parallel word; must be ≥ 2.
- `lw`, `$clog2(n_lanes)`: width of the lane index (derived parameter, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on `posedge clk`.
- `req`  in  `n_lanes`  per-lane request; lane holds it high while it has a word to send.
- `serial_valid`  in  `n_lanes`  per-lane bit strobe.
- `serial_data`  in  `n_lanes`  per-lane data bit.
- `grant`  out  `n_lanes`  registered one-hot grant; all-zero when no lane is granted.
- `abort`  out  1  one-cycle pulse: the granted lane dropped `req` mid-word and the partial word was discarded.
- `out_valid`  out  1  assembled word available.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_data`  out  `width`  assembled word; first received bit is in `out_data[0]`.
- `out_lane`  out  `lw`  index of the lane that produced `out_data`.

## Operation
- FSM states: IDLE, COLLECT, HOLD. Registers: `last` (lane index), bit counter `cnt` (0..width-1), shift/assembly register.
- Reset values (`rst`=0): state IDLE, `grant`=0, `abort`=0, `out_valid`=0, `out_data`=0, `out_lane`=0, `cnt`=0, `last`=`n_lanes`-1, so lane 0 has first priority.
- IDLE with any `req` bit high:
  - Select the first requesting lane scanning from `(last+1) mod n_lanes` upward with wrap.
  - Set `grant` to that lane's one-hot, set `cnt`=0, go to COLLECT.
- IDLE with `req`=0: stay in IDLE; `grant` stays 0.
- COLLECT, granted lane g:
  - Only `serial_valid[g]` and `serial_data[g]` are used; all other lanes' strobes are ignored and lost.
  - Each cycle with `serial_valid[g]`=1 writes `serial_data[g]` to bit `cnt` and increments `cnt`.
  - When the bit written has `cnt`=`width`-1, the word is complete:
    - `out_data` = full word including this bit; `out_lane`=g; `out_valid`=1.
    - `grant`=0, `last`=g, `cnt`=0, go to HOLD.
- Abort: in COLLECT, when `req[g]`=0 and `serial_valid[g]`=0 in the same cycle:
  - Discard partial bits, set `cnt`=0, `grant`=0, `last`=g.
  - Pulse `abort` for one cycle, go to IDLE.
  - `out_*` are unchanged.
- Simultaneous completion and drop: `req[g]`=0 with the final valid bit completes the word normally; no abort.
- A non-final valid bit with `req[g]`=0 is stored and counted, then the abort rule applies from the next cycle onward.
- HOLD:
  - `out_valid`=1 and `out_data`/`out_lane` are held stable until `out_ready`=1.
  - On the handshake: `out_valid`=0 next cycle, go to IDLE.
  - No lane is granted while in HOLD (backpressure stalls all lanes).
- Reset asserted in any state returns all state to the reset values on the next edge; any partial or unaccepted word is lost without an `abort` pulse.

## Timing
- `req` high in IDLE at edge N → `grant` one-hot from N+1.
- The first bit can be accepted in the first cycle `grant` is high.
- Final bit sampled at edge T → `out_valid`=1 and `grant`=0 from T+1.
- Handshake at edge H → `out_valid`=0 and state IDLE from H+1; the next `grant` appears at H+2 if `req` is pending.
- Back-to-back word throughput on one lane: `width` + 2 cycles per word (grant cycle, `width` bits, one HOLD cycle with `out_ready`=1).
- Abort detected at edge A → `abort`=1 and `grant`=0 during cycle A+1; a new grant is possible at A+2.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset/single word:
  - Hold `rst`=0 for 3 cycles → all outputs 0.
  - Release; `req[2]`=1, feed 8 consecutive valid bits 1,0,1,1,0,0,1,0 with `out_ready`=1.
  - Required: `grant`=4'b0100 one cycle after `req`; `out_valid` one cycle after the 8th bit with `out_data`=8'h4D, `out_lane`=2.
- Round-robin:
  - All four `req` high continuously; each lane sends 8'hA5 + lane.
  - Required: grants in order 0,1,2,3,0; each word tagged with the correct `out_lane`.
- Gapped bits and ignored lanes:
  - Lane 1 granted; `serial_valid[1]` toggles 1,0,0,1,...; lane 3 strobes every cycle.
  - Required: word assembled only from lane 1's valid bits; `out_valid` after the 8th valid bit.
- Backpressure:
  - Word completes with `out_ready`=0 for 5 cycles.
  - Required: `out_valid`, `out_data` and `out_lane` stable for those cycles; `grant`=0; after `out_ready`=1, next grant exactly 2 cycles after the handshake.
- Abort and boundary:
  - Lane 0 drops `req` after 3 bits with no strobe → `abort` pulses once, no `out_valid`, lane 1 granted next.
  - Repeat with `req` dropped in the same cycle as the 8th bit → word delivered, no `abort`.
- Reset mid-word:
  - Assert `rst` after 5 bits → all outputs 0.
  - Next word after release is delivered complete and correct, and lane 0 has priority.

Source files
------------

// File: rtl/serial_deser_arbiter.sv
// serial_deser_arbiter
//   One LSB-first serial-to-parallel deserializer shared by n_lanes serial
//   requesters. A round-robin arbiter grants one lane at a time; exactly
//   `width` valid bits are collected from that lane and the assembled word is
//   offered on a valid/ready port together with the source lane index.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   rst           in   synchronous active-low reset (0 = reset)
//   req           in   [n_lanes]  per-lane request, held while a word is pending
//   serial_valid  in   [n_lanes]  per-lane bit strobe
//   serial_data   in   [n_lanes]  per-lane data bit
//   grant         out  [n_lanes]  registered one-hot grant, zero when idle
//   abort         out  one-cycle pulse, granted lane dropped req mid-word
//   out_valid     out  assembled word available
//   out_ready     in   consumer accepts on out_valid && out_ready
//   out_data      out  [width]    assembled word, first bit in bit 0
//   out_lane      out  [lw]       lane that produced out_data
//
// state   | meaning
// IDLE    | no lane granted; pick next requester round-robin after `last`
// COLLECT | lane gidx granted; shifting in its valid bits
// HOLD    | word presented on out_*; all lanes stalled until out_ready

module serial_deser_arbiter #(
  parameter int n_lanes = 4,
  parameter int width   = 8,
  localparam int lw     = $clog2(n_lanes)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [n_lanes-1:0] req,
  input  logic [n_lanes-1:0] serial_valid,
  input  logic [n_lanes-1:0] serial_data,
  output logic [n_lanes-1:0] grant,
  output logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   out_data,
  output logic [lw-1:0]      out_lane
);

  localparam int cw = $clog2(width);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [n_lanes-1:0] grant_q, grant_d;
  logic [lw-1:0]      gidx_q, gidx_d;
  logic [lw-1:0]      last_q, last_d;
  logic [cw-1:0]      cnt_q, cnt_d;
  logic [width-1:0]   shift_q, shift_d;
  logic               abort_q, abort_d;
  logic               out_valid_q, out_valid_d;
  logic [width-1:0]   out_data_q, out_data_d;
  logic [lw-1:0]      out_lane_q, out_lane_d;

  logic               pick_found;
  logic [lw-1:0]      pick_idx;
  logic [lw-1:0]      cand;
  logic [width-1:0]   word;

  // Round-robin scan starting one past the last served lane, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= n_lanes; i++) begin
      cand = lw'((int'(last_q) + i) % n_lanes);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    abort_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;

    // Partial word with the current bit of the granted lane merged in.
    word          = shift_q;
    word[cnt_q]   = serial_data[gidx_q];

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          cnt_d             = '0;
          shift_d           = '0;
          state_d           = COLLECT;
        end
      end
      COLLECT: begin
        // A valid bit takes precedence over a dropped req, so the final bit
        // arriving with req low still completes the word.
        if (serial_valid[gidx_q]) begin
          if (cnt_q == cw'(width - 1)) begin
            out_data_d  = word;
            out_lane_d  = gidx_q;
            out_valid_d = 1'b1;
            grant_d     = '0;
            last_d      = gidx_q;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + cw'(1);
          end
        end else if (!req[gidx_q]) begin
          shift_d = '0;
          cnt_d   = '0;
          grant_d = '0;
          last_d  = gidx_q;
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      last_q      <= lw'(n_lanes - 1);
      cnt_q       <= '0;
      shift_q     <= '0;
      abort_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      abort_q     <= abort_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
    end
  end

  assign grant     = grant_q;
  assign abort     = abort_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_serial_deser_arbiter.sv
// Directed bench for serial_deser_arbiter (n_lanes=4, width=8).
module tb_serial_deser_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] sv  = '0;
  logic [3:0] sd  = '0;
  logic       out_ready = 1'b0;
  logic [3:0] grant;
  logic       abort;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_lane;

  int checks   = 0;
  int failures = 0;

  serial_deser_arbiter #(.n_lanes(4), .width(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .serial_valid (sv),
    .serial_data  (sd),
    .grant        (grant),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane     (out_lane)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] sv;
    logic [3:0] sd;
    logic       rdy;
    logic [3:0] e_grant;
    logic       e_abort;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_lane;
    logic       chk_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] v,
                     input logic [3:0] d, input logic rdy, input logic [3:0] eg,
                     input logic ea, input logic ev, input logic [7:0] ed,
                     input logic [1:0] el, input logic cd);
    vec_t x;
    x.rst = r; x.req = rq; x.sv = v; x.sd = d; x.rdy = rdy;
    x.e_grant = eg; x.e_abort = ea; x.e_valid = ev; x.e_data = ed;
    x.e_lane = el; x.chk_d = cd;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed nbits valid bits of w on one lane; checks in-progress and completion.
  task automatic feed(input int lane, input logic [7:0] w, input logic [3:0] rq, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      req = rq;
      sv  = 4'(1) << lane;
      sd  = 4'(w[b]) << lane;
      tick();
      if (b < 7) begin
        chk("feed_grant", 32'(grant), 32'(4'(1) << lane));
        chk("feed_novalid", 32'(out_valid), 32'd0);
      end
    end
    sv = '0;
    sd = '0;
    if (nbits == 8) begin
      chk("word_valid", 32'(out_valid), 32'd1);
      chk("word_data", 32'(out_data), 32'(w));
      chk("word_lane", 32'(out_lane), 32'(lane));
      chk("word_grant0", 32'(grant), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] g;
    int nb;

    // Reset, single word on lane 2 (0x4D = bits 1,0,1,1,0,0,1,0).
    for (int i = 0; i < 3; i++) add(0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 8'h00, 0, 1);
    add(1, 4'b0100, 0, 0, 1, 4'b0100, 0, 0, 8'h00, 0, 1);
    w = 8'h4D;
    for (int b = 0; b < 8; b++)
      add(1, 4'b0100, 4'b0100, 4'(w[b]) << 2, 1, (b == 7) ? 4'b0000 : 4'b0100,
          0, (b == 7), (b == 7) ? 8'h4D : 8'h00, (b == 7) ? 2'd2 : 2'd0, 1);
    add(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
    // Lane 0 aborts after 3 bits; lane 1 then granted, drops req on its 8th bit.
    add(1, 4'b0001, 0, 0, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 8'h00, 0, 0);
    add(1, 4'b0010, 0, 0, 1, 4'b0000, 1, 0, 8'h00, 0, 0);
    add(1, 4'b0010, 0, 0, 1, 4'b0010, 0, 0, 8'h00, 0, 0);
    w = 8'h3C;
    for (int b = 0; b < 8; b++)
      add(1, (b == 7) ? 4'b0000 : 4'b0010, 4'b0010, 4'(w[b]) << 1, 1,
          (b == 7) ? 4'b0000 : 4'b0010, 0, (b == 7), 8'h3C, 2'd1, (b == 7));
    add(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; sv = vecs[i].sv;
      sd = vecs[i].sd; out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_abort", i), 32'(abort), 32'(vecs[i].e_abort));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].e_data));
        chk($sformatf("v%0d_lane", i), 32'(out_lane), 32'(vecs[i].e_lane));
      end
    end

    // Round-robin with all lanes requesting, after a fresh reset.
    rst = 1'b0; sv = '0; sd = '0; req = '0;
    tick();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(4'(1) << (k % 4)));
      g = 8'hA5 + 8'(k % 4);
      feed(k % 4, g, 4'b1111, 8);
      tick();
      chk($sformatf("rr%0d_hs", k), 32'(out_valid), 32'd0);
    end

    // Gapped strobes on lane 1 while lane 3 strobes 1s every cycle.
    req = 4'b0010;
    tick();
    chk("gap_grant", 32'(grant), 32'b0010);
    w  = 8'h96;
    nb = 0;
    for (int c = 0; c < 22; c++) begin
      sv = 4'b1000;
      sd = 4'b1000;
      if (c % 3 == 0) begin
        sv[1] = 1'b1;
        sd[1] = w[nb];
        nb++;
      end
      tick();
      if (c < 21) chk("gap_novalid", 32'(out_valid), 32'd0);
    end
    sv = '0; sd = '0;
    chk("gap_valid", 32'(out_valid), 32'd1);
    chk("gap_data", 32'(out_data), 32'h96);
    chk("gap_lane", 32'(out_lane), 32'd1);
    req = '0;
    tick();
    chk("gap_hs", 32'(out_valid), 32'd0);

    // Backpressure: word held for 5 cycles with other lanes requesting.
    req = 4'b0100; out_ready = 1'b0;
    tick();
    chk("bp_grant", 32'(grant), 32'b0100);
    feed(2, 8'h5A, 4'b0100, 8);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h5A);
      chk("bp_lane", 32'(out_lane), 32'd2);
      chk("bp_grant0", 32'(grant), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_grant", 32'(grant), 32'd0);
    tick();
    chk("bp_next_grant", 32'(grant), 32'b1000);
    req = '0;
    tick();
    chk("bp_abort", 32'(abort), 32'd1);
    chk("bp_abort_grant", 32'(grant), 32'd0);
    tick();
    chk("bp_abort_once", 32'(abort), 32'd0);

    // Reset in the middle of a word on lane 1.
    req = 4'b0010;
    tick();
    chk("rm_grant", 32'(grant), 32'b0010);
    feed(1, 8'hFF, 4'b0010, 5);
    rst = 1'b0;
    tick();
    chk("rm_grant0", 32'(grant), 32'd0);
    chk("rm_abort0", 32'(abort), 32'd0);
    chk("rm_valid0", 32'(out_valid), 32'd0);
    chk("rm_data0", 32'(out_data), 32'd0);
    chk("rm_lane0", 32'(out_lane), 32'd0);
    rst = 1'b1; req = 4'b1111;
    tick();
    chk("rm_prio", 32'(grant), 32'b0001);
    feed(0, 8'hC3, 4'b1111, 8);
    req = '0;
    tick();
    chk("rm_hs", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
